// File: rtl/arbiter_n_sdp_if.sv
// Request-side and memory-side signal bundle for the N-port single-port-memory arbiter.
// Slave is the arbiter's view; master is the requester/memory environment's view.
interface arbiter_n_sdp_if #(
    parameter int WIDTH     = 32,
    parameter int IDX_SIZE  = 4,
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS*IDX_SIZE-1:0] addr;
    logic [NUM_PORTS*WIDTH-1:0]    in;
    logic [NUM_PORTS-1:0]          write_en;
    logic [NUM_PORTS-1:0]          read_en;
    logic                          mem_write_done;
    logic                          mem_read_done;
    logic [WIDTH-1:0]              mem_out;
    logic [NUM_PORTS*WIDTH-1:0]    out;
    logic [NUM_PORTS-1:0]          write_done;
    logic [NUM_PORTS-1:0]          read_done;
    logic [NUM_PORTS-1:0]          grant;
    logic [IDX_SIZE-1:0]           mem_addr;
    logic [WIDTH-1:0]              mem_in;
    logic                          mem_write_en;
    logic                          mem_read_en;

    modport slave (
        input  addr, in, write_en, read_en, mem_write_done, mem_read_done, mem_out,
        output out, write_done, read_done, grant, mem_addr, mem_in, mem_write_en, mem_read_en
    );

    modport master (
        output addr, in, write_en, read_en, mem_write_done, mem_read_done, mem_out,
        input  out, write_done, read_done, grant, mem_addr, mem_in, mem_write_en, mem_read_en
    );
endinterface

// File: rtl/arbiter_n_sdp.sv
// Round-robin / fixed-priority arbiter sharing one dynamic-latency single-port memory
// among NUM_PORTS requesters; request fields are latched at grant.
module arbiter_n_sdp #(
    parameter int WIDTH         = 32,
    parameter int SIZE          = 16,
    parameter int IDX_SIZE      = 4,
    parameter int NUM_PORTS     = 4,
    parameter int PRIORITY_MODE = 0
) (
    input  logic            clk,
    input  logic            reset,
    arbiter_n_sdp_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_PORTS);
    typedef logic [PTR_W-1:0] idx_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    if (NUM_PORTS < 2) begin : g_chk_ports
        $error("arbiter_n_sdp: NUM_PORTS must be at least 2");
    end
    if (SIZE > (1 << IDX_SIZE)) begin : g_chk_size
        $error("arbiter_n_sdp: SIZE exceeds the IDX_SIZE address space");
    end

    state_t               state_q, state_d;
    idx_t                 ptr_q, ptr_d;
    idx_t                 idx_q, idx_d;
    logic [IDX_SIZE-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 wr_q, wr_d;
    logic [NUM_PORTS-1:0] wdone_q, wdone_d;
    logic [NUM_PORTS-1:0] rdone_q, rdone_d;
    logic [WIDTH-1:0]     out_q [NUM_PORTS];
    logic [WIDTH-1:0]     out_d [NUM_PORTS];

    logic [IDX_SIZE-1:0]  addr_a [NUM_PORTS];
    logic [WIDTH-1:0]     in_a   [NUM_PORTS];
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] grant_c;
    logic                 found;
    idx_t                 win;
    idx_t                 cand;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ports
        assign addr_a[p] = bus.addr[p*IDX_SIZE +: IDX_SIZE];
        assign in_a[p]   = bus.in[p*WIDTH +: WIDTH];
        assign bus.out[p*WIDTH +: WIDTH] = out_q[p];
    end

    // A port asserting both enables is treated as a write.
    assign req = bus.write_en | bus.read_en;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (PRIORITY_MODE != 0) begin
                cand = idx_t'(k);
            end else begin
                cand = idx_t'((32'(ptr_q) + 32'd1 + k) % NUM_PORTS);
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        wdone_d = '0;
        rdone_d = '0;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    ptr_d   = win;
                    idx_d   = win;
                    addr_d  = addr_a[win];
                    data_d  = in_a[win];
                    wr_d    = bus.write_en[win];
                end
            end
            BUSY: begin
                // Only the done matching the latched op can end the transaction.
                if (wr_q && bus.mem_write_done) begin
                    state_d        = DONE;
                    wdone_d[idx_q] = 1'b1;
                end else if (!wr_q && bus.mem_read_done) begin
                    state_d        = DONE;
                    rdone_d[idx_q] = 1'b1;
                    out_d[idx_q]   = bus.mem_out;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= idx_t'(NUM_PORTS - 1);
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            wdone_q <= '0;
            rdone_q <= '0;
            out_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            wdone_q <= wdone_d;
            rdone_q <= rdone_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        grant_c = '0;
        if (state_q != IDLE) grant_c[idx_q] = 1'b1;
    end

    assign bus.grant        = grant_c;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_in       = data_q;
    assign bus.mem_write_en = (state_q == BUSY) && wr_q;
    assign bus.mem_read_en  = (state_q == BUSY) && !wr_q;
    assign bus.write_done   = wdone_q;
    assign bus.read_done    = rdone_q;
endmodule

// File: tb/tb_arbiter_n_sdp.sv
// Directed bench for arbiter_n_sdp: a round-robin instance and a fixed-priority instance
// share clock and reset; each is driven through its own interface.
module tb_arbiter_n_sdp;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    arbiter_n_sdp_if #(.WIDTH(32), .IDX_SIZE(4), .NUM_PORTS(4)) bus_rr ();
    arbiter_n_sdp_if #(.WIDTH(32), .IDX_SIZE(4), .NUM_PORTS(4)) bus_fp ();

    arbiter_n_sdp #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4), .NUM_PORTS(4), .PRIORITY_MODE(0)) dut (
        .clk(clk), .reset(reset), .bus(bus_rr));
    arbiter_n_sdp #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4), .NUM_PORTS(4), .PRIORITY_MODE(1)) dut_fp (
        .clk(clk), .reset(reset), .bus(bus_fp));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_oh;

    initial begin
        bus_rr.addr = '0; bus_rr.in = '0; bus_rr.write_en = '0; bus_rr.read_en = '0;
        bus_rr.mem_write_done = 1'b0; bus_rr.mem_read_done = 1'b0; bus_rr.mem_out = '0;
        bus_fp.addr = '0; bus_fp.in = '0; bus_fp.write_en = '0; bus_fp.read_en = '0;
        bus_fp.mem_write_done = 1'b0; bus_fp.mem_read_done = 1'b0; bus_fp.mem_out = '0;

        #3;
        chk("rst_grant", 64'(bus_rr.grant), 64'h0);
        chk("rst_wen", 64'(bus_rr.mem_write_en), 64'h0);
        chk("rst_ren", 64'(bus_rr.mem_read_en), 64'h0);
        chk("rst_addr", 64'(bus_rr.mem_addr), 64'h0);
        chk("rst_out_lo", bus_rr.out[63:0], 64'h0);
        chk("rst_fp_grant", 64'(bus_fp.grant), 64'h0);
        #9 reset = 1'b1;

        // Round-robin: all ports write continuously, memory always ready.
        for (int p = 0; p < 4; p++) bus_rr.in[p*32 +: 32] = 32'h100 + 32'(p);
        bus_rr.write_en = 4'hF;
        bus_rr.mem_write_done = 1'b1;
        for (int t = 0; t < 5; t++) begin
            exp_oh = 4'b0001 << (t % 4);
            tick();
            chk("rr_grant", 64'(bus_rr.grant), 64'(exp_oh));
            chk("rr_mem_in", 64'(bus_rr.mem_in), 64'h100 + 64'(t % 4));
            chk("rr_wen", 64'(bus_rr.mem_write_en), 64'h1);
            tick();
            chk("rr_wdone", 64'(bus_rr.write_done), 64'(exp_oh));
            tick();
            chk("rr_idle_grant", 64'(bus_rr.grant), 64'h0);
            chk("rr_idle_wdone", 64'(bus_rr.write_done), 64'h0);
        end
        bus_rr.write_en = '0;
        bus_rr.mem_write_done = 1'b0;

        // Single read on port 2, requester drops en while busy.
        bus_rr.read_en = 4'b0100;
        bus_rr.addr[8 +: 4] = 4'd5;
        tick();
        chk("rd_grant", 64'(bus_rr.grant), 64'h4);
        chk("rd_ren", 64'(bus_rr.mem_read_en), 64'h1);
        chk("rd_wen", 64'(bus_rr.mem_write_en), 64'h0);
        chk("rd_addr", 64'(bus_rr.mem_addr), 64'h5);
        bus_rr.read_en = '0;
        tick();
        chk("rd_hold_ren", 64'(bus_rr.mem_read_en), 64'h1);
        bus_rr.mem_read_done = 1'b1;
        bus_rr.mem_out = 32'hDEADBEEF;
        tick();
        chk("rd_done", 64'(bus_rr.read_done), 64'h4);
        chk("rd_out2", 64'(bus_rr.out[64 +: 32]), 64'hDEADBEEF);
        chk("rd_out0", 64'(bus_rr.out[0 +: 32]), 64'h0);
        chk("rd_out1", 64'(bus_rr.out[32 +: 32]), 64'h0);
        chk("rd_out3", 64'(bus_rr.out[96 +: 32]), 64'h0);
        chk("rd_done_grant", 64'(bus_rr.grant), 64'h4);
        chk("rd_done_ren", 64'(bus_rr.mem_read_en), 64'h0);
        bus_rr.mem_read_done = 1'b0;
        bus_rr.mem_out = '0;
        tick();
        chk("rd_pulse_end", 64'(bus_rr.read_done), 64'h0);
        chk("rd_idle_grant", 64'(bus_rr.grant), 64'h0);
        chk("rd_addr_hold", 64'(bus_rr.mem_addr), 64'h5);

        // Both enables on port 0: treated as a write.
        bus_rr.write_en = 4'b0001;
        bus_rr.read_en = 4'b0001;
        bus_rr.in[0 +: 32] = 32'hA5;
        tick();
        chk("both_grant", 64'(bus_rr.grant), 64'h1);
        chk("both_wen", 64'(bus_rr.mem_write_en), 64'h1);
        chk("both_ren", 64'(bus_rr.mem_read_en), 64'h0);
        chk("both_mem_in", 64'(bus_rr.mem_in), 64'hA5);
        bus_rr.write_en = '0;
        bus_rr.read_en = '0;
        bus_rr.mem_write_done = 1'b1;
        tick();
        chk("both_wdone", 64'(bus_rr.write_done), 64'h1);
        chk("both_rdone", 64'(bus_rr.read_done), 64'h0);
        bus_rr.mem_write_done = 1'b0;
        tick();

        // Wrong done type on a port-1 read.
        bus_rr.read_en = 4'b0010;
        bus_rr.addr[4 +: 4] = 4'd3;
        tick();
        chk("wd_grant", 64'(bus_rr.grant), 64'h2);
        bus_rr.read_en = '0;
        bus_rr.mem_write_done = 1'b1;
        tick();
        chk("wd_still_busy", 64'(bus_rr.mem_read_en), 64'h1);
        chk("wd_no_rdone", 64'(bus_rr.read_done), 64'h0);
        chk("wd_no_wdone", 64'(bus_rr.write_done), 64'h0);
        bus_rr.mem_write_done = 1'b0;
        bus_rr.mem_read_done = 1'b1;
        bus_rr.mem_out = 32'h12345678;
        tick();
        chk("wd_rdone", 64'(bus_rr.read_done), 64'h2);
        chk("wd_out1", 64'(bus_rr.out[32 +: 32]), 64'h12345678);
        chk("wd_out2_kept", 64'(bus_rr.out[64 +: 32]), 64'hDEADBEEF);
        bus_rr.mem_read_done = 1'b0;
        bus_rr.mem_out = '0;
        tick();

        // Async reset mid-BUSY, then port 0 wins first after release.
        bus_rr.write_en = 4'b0100;
        bus_rr.addr[8 +: 4] = 4'd7;
        tick();
        chk("ar_busy_grant", 64'(bus_rr.grant), 64'h4);
        bus_rr.mem_write_done = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("ar_grant", 64'(bus_rr.grant), 64'h0);
        chk("ar_wen", 64'(bus_rr.mem_write_en), 64'h0);
        chk("ar_addr", 64'(bus_rr.mem_addr), 64'h0);
        chk("ar_out2", 64'(bus_rr.out[64 +: 32]), 64'h0);
        chk("ar_wdone", 64'(bus_rr.write_done), 64'h0);
        bus_rr.write_en = 4'b0101;
        #2 reset = 1'b1;
        tick();
        chk("ar_first_grant", 64'(bus_rr.grant), 64'h1);
        chk("ar_stale_done", 64'(bus_rr.write_done), 64'h0);
        tick();
        chk("ar_first_wdone", 64'(bus_rr.write_done), 64'h1);
        bus_rr.write_en = '0;
        bus_rr.mem_write_done = 1'b0;
        tick();

        // Fixed priority: ports 1 and 3 request continuously.
        bus_fp.write_en = 4'b1010;
        bus_fp.mem_write_done = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("fp_grant", 64'(bus_fp.grant), 64'h2);
            tick();
            chk("fp_wdone", 64'(bus_fp.write_done), 64'h2);
            tick();
            chk("fp_idle", 64'(bus_fp.grant), 64'h0);
        end
        bus_fp.write_en = '0;
        bus_fp.mem_write_done = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
